// File: rtl/filt_addr_pkg.sv
// filt_addr_pkg: shared FSM state encoding and default widths for the window address generator
package filt_addr_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DIM_W = 16;
endpackage

// File: rtl/filt_dim_counter.sv
// filt_dim_counter: W-bit index counter that wraps to 0 after lim-1
// Ports: clk, rst (async high); clr loads zero (wins over en); en advances; lim is the
// element count; cnt is the index; tc flags cnt == lim-1.
module filt_dim_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  // lim-1 is evaluated in W bits, so lim = 2^W-1 needs no extra width
  always_comb begin
    tc = cnt_q == lim - W'(1);
    cnt_d = clr ? '0 : en ? (tc ? '0 : cnt_q + W'(1)) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/filt_window_addr_gen.sv
// filt_window_addr_gen: raster-order 2-D window address generator with pause, clear and level done
// Ports: clk, rst (async high); start/clear/pause controls; base_addr, col_stride, line_pitch,
// num_cols, num_rows config (latched on an accepted start); addr, addr_valid, col_idx, row_idx,
// last, busy, done status.
module filt_window_addr_gen
  import filt_addr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              pause,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] col_stride,
  input  logic [ADDR_W-1:0] line_pitch,
  input  logic [DIM_W-1:0]  num_cols,
  input  logic [DIM_W-1:0]  num_rows,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic [DIM_W-1:0]  col_idx,
  output logic [DIM_W-1:0]  row_idx,
  output logic              last,
  output logic              busy,
  output logic              done
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, row_base_q, row_base_d;
  logic [ADDR_W-1:0] stride_q, stride_d, pitch_q, pitch_d;
  logic [DIM_W-1:0] cols_q, cols_d, rows_q, rows_d;
  logic start_ok, zero_dim, accept, step, col_tc, row_tc, idx_clr;
  always_comb begin
    start_ok = start && state_q != RUN && !clear;
    zero_dim = num_cols == '0 || num_rows == '0;
    accept = state_q == RUN && !pause;
    last = state_q == RUN && col_tc && row_tc;
    // indices hold their final values on the last accept
    step = accept && !last;
    idx_clr = clear || start_ok;
    state_d = clear ? IDLE : start_ok ? (zero_dim ? DONE : RUN) : (accept && last) ? DONE : state_q;
    addr_d = clear ? '0 : (start_ok && !zero_dim) ? base_addr :
             step ? (col_tc ? row_base_q + pitch_q : addr_q + stride_q) : addr_q;
    row_base_d = clear ? '0 : (start_ok && !zero_dim) ? base_addr :
                 (step && col_tc) ? row_base_q + pitch_q : row_base_q;
    stride_d = start_ok ? col_stride : stride_q;
    pitch_d = start_ok ? line_pitch : pitch_q;
    cols_d = start_ok ? num_cols : cols_q;
    rows_d = start_ok ? num_rows : rows_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      row_base_q <= '0;
      stride_q <= '0;
      pitch_q <= '0;
      cols_q <= '0;
      rows_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      row_base_q <= row_base_d;
      stride_q <= stride_d;
      pitch_q <= pitch_d;
      cols_q <= cols_d;
      rows_q <= rows_d;
    end
  filt_dim_counter #(.W(DIM_W)) u_col (
    .clk(clk), .rst(rst), .clr(idx_clr), .en(step), .lim(cols_q), .cnt(col_idx), .tc(col_tc)
  );
  filt_dim_counter #(.W(DIM_W)) u_row (
    .clk(clk), .rst(rst), .clr(idx_clr), .en(step && col_tc), .lim(rows_q), .cnt(row_idx), .tc(row_tc)
  );
  assign addr = addr_q;
  assign addr_valid = state_q == RUN;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_filt_window_addr_gen.sv
// tb_filt_window_addr_gen: table-driven and randomized check of the window address generator
module tb_filt_window_addr_gen;
  logic clk = 0, rst = 1, start = 0, clear = 0, pause = 0;
  logic [31:0] base_addr = 0, col_stride = 0, line_pitch = 0, addr;
  logic [15:0] num_cols = 0, num_rows = 0, col_idx, row_idx;
  logic addr_valid, last, busy, done;
  int n_vec = 0, n_err = 0;

  typedef struct {
    logic [31:0] base, stride, pitch;
    int cols, rows, pmode, ev_kind, ev_idx;
    logic [31:0] exp_first, exp_final;
  } vec_t;

  filt_window_addr_gen dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .pause(pause),
    .base_addr(base_addr), .col_stride(col_stride), .line_pitch(line_pitch),
    .num_cols(num_cols), .num_rows(num_rows), .addr(addr), .addr_valid(addr_valid),
    .col_idx(col_idx), .row_idx(row_idx), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // element k of the window is base + row*pitch + col*stride, modulo 2^32
  function automatic logic [31:0] m_addr(input vec_t v, input int k);
    logic [31:0] r, c;
    r = k / v.cols;
    c = k % v.cols;
    return v.base + r * v.pitch + c * v.stride;
  endfunction

  // pmode: 0 no pause, 1 random pause, 2 pause 3 cycles at element 1
  // ev_kind: 0 none, 1 start pulse during RUN at ev_idx, 2 clear at ev_idx
  task automatic run(input vec_t v);
    int total, k, hold, budget;
    bit p;
    total = v.cols * v.rows;
    base_addr = v.base; col_stride = v.stride; line_pitch = v.pitch;
    num_cols = v.cols[15:0]; num_rows = v.rows[15:0];
    start = 1; pause = 0;
    @(posedge clk); #1;
    start = 0;
    base_addr = $urandom; col_stride = $urandom; line_pitch = $urandom;
    num_cols = 16'($urandom); num_rows = 16'($urandom);
    if (total == 0) begin
      chk("zero_valid", addr_valid, 0);
      chk("zero_done", done, 1);
      @(posedge clk); #1;
      chk("zero_valid2", addr_valid, 0);
      chk("zero_done2", done, 1);
      return;
    end
    chk("first_addr", addr, v.exp_first);
    k = 0; hold = 3; budget = 0;
    while (k < total && budget < 4000) begin
      budget++;
      chk("valid", addr_valid, 1);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("addr", addr, m_addr(v, k));
      chk("col_idx", col_idx, k % v.cols);
      chk("row_idx", row_idx, k / v.cols);
      chk("last", last, k == total - 1);
      p = v.pmode == 1 ? $urandom_range(0, 2) == 0 : (v.pmode == 2 && k == 1 && hold > 0);
      if (v.pmode == 2 && k == 1 && hold > 0) hold--;
      pause = p;
      start = v.ev_kind == 1 && k == v.ev_idx;
      if (v.ev_kind == 2 && k == v.ev_idx) begin
        clear = 1;
        @(posedge clk); #1;
        clear = 0; pause = 0;
        chk("clr_valid", addr_valid, 0);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_addr", addr, v.exp_final);
        chk("clr_col", col_idx, 0);
        chk("clr_row", row_idx, 0);
        return;
      end
      @(posedge clk); #1;
      start = 0;
      if (!p) k++;
    end
    pause = 0;
    chk("walk_count", k, total);
    chk("end_valid", addr_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_done", done, 1);
    chk("end_addr", addr, v.exp_final);
    chk("end_addr_model", addr, m_addr(v, total - 1));
    chk("end_col", col_idx, (total - 1) % v.cols);
    @(posedge clk); #1;
    chk("done_hold", done, 1);
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    tbl[0] = '{32'h100, 1, 8, 3, 2, 0, 0, 0, 32'h100, 32'h10A};
    tbl[1] = '{32'h100, 1, 8, 3, 2, 2, 0, 0, 32'h100, 32'h10A};
    tbl[2] = '{32'h200, 1, 1, 0, 5, 0, 0, 0, 32'h0, 32'h0};
    tbl[3] = '{32'hFFFFFFFE, 1, 0, 4, 1, 0, 0, 0, 32'hFFFFFFFE, 32'h1};
    tbl[4] = '{32'h4000, 4, 32'h100, 2, 3, 1, 0, 0, 32'h4000, 32'h4204};
    tbl[5] = '{32'h100, 1, 8, 3, 2, 0, 1, 1, 32'h100, 32'h10A};
    tbl[6] = '{32'h100, 1, 8, 3, 2, 0, 2, 3, 32'h100, 32'h0};
    tbl[7] = '{32'h0, 2, 0, 65535, 2, 0, 2, 5, 32'h0, 32'h0};
    @(posedge clk); #1;
    chk("rst_addr", addr, 0);
    chk("rst_valid", addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_col", col_idx, 0);
    chk("rst_row", row_idx, 0);
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) run(tbl[i]);
    // async reset between edges at element 2
    base_addr = 32'h100; col_stride = 1; line_pitch = 8; num_cols = 3; num_rows = 2;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_addr", addr, 32'h102);
    #2 rst = 1;
    #1;
    chk("arst_addr", addr, 0);
    chk("arst_valid", addr_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_col", col_idx, 0);
    chk("arst_row", row_idx, 0);
    rst = 0;
    @(posedge clk); #1;
    run(tbl[0]);
    for (int i = 0; i < 25; i++) begin
      rv.base = $urandom; rv.stride = $urandom; rv.pitch = $urandom;
      rv.cols = $urandom_range(0, 5); rv.rows = $urandom_range(1, 4);
      rv.pmode = 1;
      rv.ev_kind = $urandom_range(0, 4) == 0 ? 2 : 0;
      rv.ev_idx = $urandom_range(0, 3);
      rv.exp_first = rv.base;
      if (rv.ev_kind == 2 && rv.ev_idx >= rv.cols * rv.rows) rv.ev_kind = 0;
      rv.exp_final = rv.ev_kind == 2 ? 32'h0 : (rv.cols == 0 ? 32'h0 : m_addr(rv, rv.cols * rv.rows - 1));
      run(rv);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
